// File: rtl/novck_pkg.sv
// -----------------------------------------------------------------------------
// novck_pkg
// Shared definitions for the two-phase non-overlapping clock monitor:
//   - novck_state_t     : phase-tracking FSM states
//   - NOVCK_CNT_W_DEF   : default gap counter / gap output width
//   - NOVCK_MIN_GAP_DEF : default minimum legal gap, in CK cycles
// -----------------------------------------------------------------------------
package novck_pkg;

  localparam int NOVCK_CNT_W_DEF   = 8;
  localparam int NOVCK_MIN_GAP_DEF = 2;

  // IDLE waits for a phase-1 rise so every measurement starts on PH1.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    P1_HI = 3'd1,
    GAP12 = 3'd2,
    P2_HI = 3'd3,
    GAP21 = 3'd4
  } novck_state_t;

endpackage : novck_pkg

// File: rtl/novck_sync.sv
// -----------------------------------------------------------------------------
// novck_sync
// Single-bit multi-flop synchronizer bringing an asynchronous phase clock into
// the CK domain. Depth is clamped to at least two flops.
//
// Ports:
//   CK  in  sampling clock, rising edge
//   RST in  synchronous active-high reset (all stages cleared)
//   d   in  asynchronous input
//   q   out synchronized output (last stage)
// -----------------------------------------------------------------------------
module novck_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CK,
  input  logic RST,
  input  logic d,
  output logic q
);

  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge CK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule : novck_sync

// File: rtl/novck_monitor.sv
// -----------------------------------------------------------------------------
// novck_monitor
// Receiving-end checker for a two-phase non-overlapping clock pair. Samples
// PH1/PH2 with the faster CK, tracks the PH1 -> gap -> PH2 -> gap sequence,
// measures both non-overlap gaps in CK cycles and flags overlap, short-gap and
// out-of-sequence errors. locked indicates a clean full period was observed.
//
// Ports:
//   CK          in   sampling clock, rising edge
//   RST         in   synchronous active-high reset
//   PH1, PH2    in   phase clocks under test, asynchronous to CK
//   clr_err     in   one-cycle pulse clearing the sticky error flags
//   gap12       out  last PH1-fall to PH2-rise gap (CK cycles, saturating)
//   gap21       out  last PH2-fall to PH1-rise gap (CK cycles, saturating)
//   meas_valid  out  one-cycle pulse when gap21 updates (period complete)
//   overlap_err out  sticky: PH1 and PH2 seen high together
//   gap_err     out  sticky: a latched gap was below MIN_GAP
//   seq_err     out  sticky: same phase seen twice with no other between
//   locked      out  high after a clean full period, low on any error
//
// Optional build macro NOVCK_MON_MINMAX_EN adds:
//   gap_min     out  smallest latched gap since reset/clr_err (reset all-ones)
//   gap_max     out  largest latched gap since reset/clr_err (reset zero)
// -----------------------------------------------------------------------------
module novck_monitor
  import novck_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = NOVCK_CNT_W_DEF,
  parameter int MIN_GAP     = NOVCK_MIN_GAP_DEF
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             PH1,
  input  logic             PH2,
  input  logic             clr_err,
  output logic [CNT_W-1:0] gap12,
  output logic [CNT_W-1:0] gap21,
  output logic             meas_valid,
  output logic             overlap_err,
  output logic             gap_err,
  output logic             seq_err,
  output logic             locked
`ifdef NOVCK_MON_MINMAX_EN
  ,
  output logic [CNT_W-1:0] gap_min,
  output logic [CNT_W-1:0] gap_max
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_GAP_C = CNT_W'(MIN_GAP);

  // ---------------------------------------------------------------------------
  // Synchronizers
  // ---------------------------------------------------------------------------
  logic s1;
  logic s2;

  novck_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ph1 (
    .CK  (CK),
    .RST (RST),
    .d   (PH1),
    .q   (s1)
  );

  novck_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ph2 (
    .CK  (CK),
    .RST (RST),
    .d   (PH2),
    .q   (s2)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  novck_state_t     state_q,       state_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic [CNT_W-1:0] gap12_q,       gap12_d;
  logic [CNT_W-1:0] gap21_q,       gap21_d;
  logic             meas_valid_q,  meas_valid_d;
  logic             overlap_err_q, overlap_err_d;
  logic             gap_err_q,     gap_err_d;
  logic             seq_err_q,     seq_err_d;
  logic             locked_q,      locked_d;
  // Only the phase-1 edge is needed: IDLE aligns on PH1 and every other
  // transition is decided on phase levels.
  logic             p1_q,          p1_d;
  // Set when a short gap12 was latched in the period now in progress, so the
  // period's completion can withhold lock.
  logic             period_err_q,  period_err_d;

  logic             s1_rise;
  logic             gap_short;
  logic [CNT_W-1:0] cnt_inc;
  logic             overlap_set;
  logic             gap_set;
  logic             seq_set;

  assign s1_rise   = s1 & ~p1_q;
  assign gap_short = (cnt_q < MIN_GAP_C);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap12_d      = gap12_q;
    gap21_d      = gap21_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    period_err_d = period_err_q;
    p1_d         = s1;
    overlap_set  = 1'b0;
    gap_set      = 1'b0;
    seq_set      = 1'b0;

    if (s1 && s2) begin
      // Overlap overrides everything: abandon the period and realign on PH1.
      overlap_set = 1'b1;
      locked_d    = 1'b0;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (s1_rise) begin
            state_d      = P1_HI;
            period_err_d = 1'b0;
          end
        end

        P1_HI: begin
          if (!s1) begin
            state_d = GAP12;
            cnt_d   = CNT_ONE;
          end
        end

        GAP12: begin
          if (s2) begin
            gap12_d = cnt_q;
            state_d = P2_HI;
            if (gap_short) begin
              gap_set      = 1'b1;
              period_err_d = 1'b1;
            end
          end else if (s1) begin
            seq_set      = 1'b1;
            locked_d     = 1'b0;
            state_d      = P1_HI;
            period_err_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        P2_HI: begin
          if (!s2) begin
            state_d = GAP21;
            cnt_d   = CNT_ONE;
          end
        end

        GAP21: begin
          if (s1) begin
            gap21_d      = cnt_q;
            meas_valid_d = 1'b1;
            gap_set      = gap_short;
            locked_d     = ~(period_err_q | gap_short);
            state_d      = P1_HI;
            period_err_d = 1'b0;
          end else if (s2) begin
            seq_set  = 1'b1;
            locked_d = 1'b0;
            state_d  = P2_HI;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Sticky flags: a new detection wins over a simultaneous clear.
    overlap_err_d = overlap_set | (overlap_err_q & ~clr_err);
    gap_err_d     = gap_set     | (gap_err_q     & ~clr_err);
    seq_err_d     = seq_set     | (seq_err_q     & ~clr_err);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      gap12_q       <= '0;
      gap21_q       <= '0;
      meas_valid_q  <= 1'b0;
      overlap_err_q <= 1'b0;
      gap_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      locked_q      <= 1'b0;
      p1_q          <= 1'b0;
      period_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap12_q       <= gap12_d;
      gap21_q       <= gap21_d;
      meas_valid_q  <= meas_valid_d;
      overlap_err_q <= overlap_err_d;
      gap_err_q     <= gap_err_d;
      seq_err_q     <= seq_err_d;
      locked_q      <= locked_d;
      p1_q          <= p1_d;
      period_err_q  <= period_err_d;
    end
  end

  assign gap12       = gap12_q;
  assign gap21       = gap21_q;
  assign meas_valid  = meas_valid_q;
  assign overlap_err = overlap_err_q;
  assign gap_err     = gap_err_q;
  assign seq_err     = seq_err_q;
  assign locked      = locked_q;

`ifdef NOVCK_MON_MINMAX_EN
  // ---------------------------------------------------------------------------
  // Min/max tracking over every latched gap (either direction)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] gap_min_q, gap_min_d;
  logic [CNT_W-1:0] gap_max_q, gap_max_d;
  logic             gap_latch;

  // Mirrors the latch conditions above; overlap has priority, hence the
  // opposite-phase-low terms.
  assign gap_latch = ((state_q == GAP12) && s2 && !s1) ||
                     ((state_q == GAP21) && s1 && !s2);

  always_comb begin
    // clr_err restarts tracking; a gap latched in the same cycle is the first
    // sample of the new window.
    gap_min_d = clr_err ? CNT_MAX : gap_min_q;
    gap_max_d = clr_err ? '0      : gap_max_q;
    if (gap_latch) begin
      if (cnt_q < gap_min_d) gap_min_d = cnt_q;
      if (cnt_q > gap_max_d) gap_max_d = cnt_q;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      gap_min_q <= CNT_MAX;
      gap_max_q <= '0;
    end else begin
      gap_min_q <= gap_min_d;
      gap_max_q <= gap_max_d;
    end
  end

  assign gap_min = gap_min_q;
  assign gap_max = gap_max_q;
`endif

endmodule : novck_monitor

// File: tb/tb_novck_monitor.sv
// -----------------------------------------------------------------------------
// tb_novck_monitor
// Directed testbench for novck_monitor. The stimulus thread drives PH1/PH2 as
// whole-cycle phase segments and pushes the expected measurement of each
// period just before the PH1 rise that completes it; a monitor thread pops and
// compares on every meas_valid. Status flags are checked directly at fixed
// points in the sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_novck_monitor;
  import novck_pkg::*;

  localparam int CNT_W = 8;

  logic             CK = 1'b0;
  logic             RST;
  logic             PH1;
  logic             PH2;
  logic             clr_err;
  logic [CNT_W-1:0] gap12;
  logic [CNT_W-1:0] gap21;
  logic             meas_valid;
  logic             overlap_err;
  logic             gap_err;
  logic             seq_err;
  logic             locked;
`ifdef NOVCK_MON_MINMAX_EN
  logic [CNT_W-1:0] gap_min;
  logic [CNT_W-1:0] gap_max;
`endif

  novck_monitor #(
    .SYNC_STAGES (2),
    .CNT_W       (CNT_W),
    .MIN_GAP     (2)
  ) dut (
    .CK          (CK),
    .RST         (RST),
    .PH1         (PH1),
    .PH2         (PH2),
    .clr_err     (clr_err),
    .gap12       (gap12),
    .gap21       (gap21),
    .meas_valid  (meas_valid),
    .overlap_err (overlap_err),
    .gap_err     (gap_err),
    .seq_err     (seq_err),
    .locked      (locked)
`ifdef NOVCK_MON_MINMAX_EN
    ,
    .gap_min     (gap_min),
    .gap_max     (gap_max)
`endif
  );

  always #5 CK = ~CK;

  int total = 0;
  int bad   = 0;
  int n_push = 0;
  int n_meas = 0;

  typedef struct {
    int g12;
    int g21;
    int lk;
    int ov;
    int ge;
    int se;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int g12, input int g21, input int lk,
                      input int ov, input int ge, input int se);
    exp_t e;
    e.g12 = g12; e.g21 = g21; e.lk = lk; e.ov = ov; e.ge = ge; e.se = se;
    sb_q.push_back(e);
    n_push++;
  endtask

  // Hold the phase pins for n CK cycles; returns 1ns after the last edge.
  task automatic hold(input logic a, input logic b, input int n);
    PH1 = a;
    PH2 = b;
    repeat (n) @(posedge CK);
    #1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge CK);
    #1;
    clr_err = 1'b0;
  endtask

  // Scoreboard monitor: compare every completed period.
  always @(negedge CK) begin
    if (meas_valid) begin
      n_meas++;
      check("meas_expected", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("mv_gap12",   int'(gap12),       mon_e.g12);
        check("mv_gap21",   int'(gap21),       mon_e.g21);
        check("mv_locked",  int'(locked),      mon_e.lk);
        check("mv_overlap", int'(overlap_err), mon_e.ov);
        check("mv_gap_err", int'(gap_err),     mon_e.ge);
        check("mv_seq_err", int'(seq_err),     mon_e.se);
      end
    end
  end

  // Watchdog: the directed sequence is a few thousand cycles at most.
  initial begin
    repeat (20000) @(posedge CK);
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; PH1 = 1'b0; PH2 = 1'b0; clr_err = 1'b0;
    repeat (4) @(posedge CK);
    #1;
    // Reset state
    check("rst_gap12",   int'(gap12),       0);
    check("rst_gap21",   int'(gap21),       0);
    check("rst_mv",      int'(meas_valid),  0);
    check("rst_overlap", int'(overlap_err), 0);
    check("rst_gap_err", int'(gap_err),     0);
    check("rst_seq_err", int'(seq_err),     0);
    check("rst_locked",  int'(locked),      0);
`ifdef NOVCK_MON_MINMAX_EN
    check("rst_gap_min", int'(gap_min), 255);
    check("rst_gap_max", int'(gap_max), 0);
`endif
    RST = 1'b0;
    hold(1'b0, 1'b0, 3);

    // 1. Clean pattern, three periods
    for (int p = 0; p < 3; p++) begin
      hold(1'b1, 1'b0, 10);
      hold(1'b0, 1'b0, 3);
      hold(1'b0, 1'b1, 10);
      hold(1'b0, 1'b0, 4);
      push(3, 4, 1, 0, 0, 0);
    end
    hold(1'b1, 1'b0, 10);
    check("clean_locked",  int'(locked),      1);
    check("clean_overlap", int'(overlap_err), 0);

    // 2. Overlap: PH2 rises two cycles before PH1 falls
    hold(1'b1, 1'b1, 2);
    hold(1'b0, 1'b1, 1);
    check("ovl_err",    int'(overlap_err), 1);
    check("ovl_locked", int'(locked),      0);
    hold(1'b0, 1'b1, 7);
    hold(1'b0, 1'b0, 4);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 3);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 4);
    push(3, 4, 1, 1, 0, 0);
    hold(1'b1, 1'b0, 5);
    check("ovl_relock", int'(locked), 1);
    pulse_clr();
    check("ovl_cleared",     int'(overlap_err), 0);
    check("clr_keeps_lock",  int'(locked),      1);
    hold(1'b1, 1'b0, 4);

    // 3. Short gap12 of one cycle
    hold(1'b0, 1'b0, 1);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 4);
    push(1, 4, 0, 0, 1, 0);
    hold(1'b1, 1'b0, 5);
    check("short_gap_err", int'(gap_err), 1);
    check("short_locked",  int'(locked),  0);
    pulse_clr();
    check("short_cleared", int'(gap_err), 0);
    hold(1'b1, 1'b0, 4);

    // 4. Two PH1 pulses with no PH2 between
    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b0, 10);
    check("seq_err",       int'(seq_err), 1);
    check("seq_gap12",     int'(gap12),   1);
    check("seq_locked",    int'(locked),  0);
    check("seq_state",     int'(dut.state_q), int'(P1_HI));
    hold(1'b0, 1'b0, 3);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 4);
    push(3, 4, 1, 0, 0, 1);
    hold(1'b1, 1'b0, 5);
    pulse_clr();
    check("seq_cleared", int'(seq_err), 0);
    hold(1'b1, 1'b0, 4);

    // 5. Saturating gap21 of 300 cycles
    hold(1'b0, 1'b0, 3);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 300);
    push(3, 255, 1, 0, 0, 0);
    hold(1'b1, 1'b0, 10);
    check("sat_gap21",   int'(gap21),   255);
    check("sat_gap_err", int'(gap_err), 0);

    // 6. Reset while in P2_HI
    hold(1'b0, 1'b0, 3);
    hold(1'b0, 1'b1, 5);
    RST = 1'b1;
    @(posedge CK);
    #1;
    RST = 1'b0;
    check("mid_rst_gap12",  int'(gap12),      0);
    check("mid_rst_gap21",  int'(gap21),      0);
    check("mid_rst_mv",     int'(meas_valid), 0);
    check("mid_rst_locked", int'(locked),     0);
    check("mid_rst_state",  int'(dut.state_q), int'(IDLE));
    hold(1'b0, 1'b1, 5);
    hold(1'b0, 1'b0, 4);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 3);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 4);
    push(3, 4, 1, 0, 0, 0);
    hold(1'b1, 1'b0, 10);
    check("post_rst_locked", int'(locked), 1);
    hold(1'b0, 1'b0, 5);

    check("sb_empty",   sb_q.size(), 0);
    check("meas_count", n_meas,      n_push);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_novck_monitor
